// File: rtl/pipelined_bypass_hazard_unit_if.sv
// rtl/pipelined_bypass_hazard_unit_if.sv - decode/stage hazard bus between pipeline control and the bypass unit
// master = pipeline control driving decode and stage state; slave = bypass/hazard unit.
interface pipelined_bypass_hazard_unit_if #(
  parameter int NUM_SRC    = 2,
  parameter int NUM_STAGES = 3,
  parameter int ADDR_W     = 5,
  parameter int SEL_W      = $clog2(NUM_STAGES + 1)
);
  logic [NUM_SRC*ADDR_W-1:0]    rs_addr;
  logic [NUM_SRC-1:0]           rs_valid;
  logic [NUM_STAGES*ADDR_W-1:0] stage_rd;
  logic [NUM_STAGES-1:0]        stage_wen;
  logic [NUM_STAGES-1:0]        stage_load;
  logic                         hold;
  logic                         flush;
  logic                         stall;
  logic [NUM_SRC*SEL_W-1:0]     bypass_sel;
  logic [31:0]                  stall_cycles;
  logic [31:0]                  bypass_events;

  modport master (
    output rs_addr, rs_valid, stage_rd, stage_wen, stage_load, hold, flush,
    input  stall, bypass_sel, stall_cycles, bypass_events
  );

  modport slave (
    input  rs_addr, rs_valid, stage_rd, stage_wen, stage_load, hold, flush,
    output stall, bypass_sel, stall_cycles, bypass_events
  );
endinterface

// File: rtl/pipelined_bypass_hazard_unit.sv
// rtl/pipelined_bypass_hazard_unit.sv - operand bypass select and load-use stall generator
// Optional perf counters enabled by defining BYPASS_PERF_COUNTERS_EN.
module pipelined_bypass_hazard_unit #(
  parameter int NUM_SRC          = 2,
  parameter int NUM_STAGES       = 3,
  parameter int ADDR_W           = 5,
  parameter int LOAD_READY_STAGE = 1
) (
  input logic clock,
  input logic reset,
  pipelined_bypass_hazard_unit_if.slave bus
);
  localparam int SEL_W = $clog2(NUM_STAGES + 1);
  localparam int CNT_W = $clog2(NUM_STAGES) + 1;

  typedef enum logic {IDLE, STALL} state_t;

  state_t                   state_q, state_d;
  logic [CNT_W-1:0]         cnt_q, cnt_d;
  logic [NUM_SRC*SEL_W-1:0] sel_d, sel_q;
  logic                     detect;
  logic [CNT_W-1:0]         need;
  logic                     ld_hit;
  logic [CNT_W-1:0]         ld_need;
  logic                     stall_o;

  // Stages scanned oldest to youngest so the youngest match overwrites.
  always_comb begin
    sel_d   = '0;
    detect  = 1'b0;
    need    = '0;
    ld_hit  = 1'b0;
    ld_need = '0;
    for (int i = 0; i < NUM_SRC; i++) begin
      ld_hit  = 1'b0;
      ld_need = '0;
      for (int k = NUM_STAGES - 1; k >= 0; k--) begin
        if (bus.rs_valid[i] && bus.stage_wen[k] &&
            (bus.rs_addr[i*ADDR_W +: ADDR_W] == bus.stage_rd[k*ADDR_W +: ADDR_W]) &&
            (bus.rs_addr[i*ADDR_W +: ADDR_W] != '0)) begin
          sel_d[i*SEL_W +: SEL_W] = SEL_W'(k + 1);
          ld_hit  = bus.stage_load[k] && (k < LOAD_READY_STAGE);
          ld_need = (k < LOAD_READY_STAGE) ? CNT_W'(LOAD_READY_STAGE - k - 1) : '0;
        end
      end
      if (ld_hit) begin
        detect = 1'b1;
        if (ld_need > need) need = ld_need;
      end
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    stall_o = 1'b0;
    case (state_q)
      IDLE: begin
        stall_o = detect;
        if (detect && (need != '0)) begin
          state_d = STALL;
          cnt_d   = need;
        end
      end
      STALL: begin
        stall_o = 1'b1;
        if (cnt_q <= CNT_W'(1)) begin
          state_d = IDLE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase
    if (bus.flush) begin
      state_d = IDLE;
      cnt_d   = '0;
    end else if (bus.hold) begin
      state_d = state_q;
      cnt_d   = cnt_q;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      sel_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      if (bus.flush)      sel_q <= '0;
      else if (bus.hold)  sel_q <= sel_q;
      else if (stall_o)   sel_q <= '0;
      else                sel_q <= sel_d;
    end
  end

  assign bus.stall      = stall_o;
  assign bus.bypass_sel = sel_q;

`ifdef BYPASS_PERF_COUNTERS_EN
  logic [31:0] stall_cnt_q;
  logic [31:0] byp_cnt_q;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      stall_cnt_q <= '0;
      byp_cnt_q   <= '0;
    end else begin
      if (stall_o && !bus.hold && !bus.flush && (stall_cnt_q != 32'hFFFF_FFFF))
        stall_cnt_q <= stall_cnt_q + 32'd1;
      if (!bus.hold && !stall_o && (|sel_d) && (byp_cnt_q != 32'hFFFF_FFFF))
        byp_cnt_q <= byp_cnt_q + 32'd1;
    end
  end

  assign bus.stall_cycles  = stall_cnt_q;
  assign bus.bypass_events = byp_cnt_q;
`else
  assign bus.stall_cycles  = 32'd0;
  assign bus.bypass_events = 32'd0;
`endif
endmodule

// File: doc/pipelined_bypass_hazard_unit.md
# pipelined_bypass_hazard_unit

Parametrised operand-bypass and load-use hazard unit for the in-order pipeline, sized by source-operand count and by number of forwarding stages. It compares decode-stage source registers against the destinations of every downstream stage and produces per-operand bypass mux selects, registered into the execute stage. On a load-use hazard it generates a multi-cycle decode stall from an internal stall counter. It sits between decode and the execute-stage operand muxes and replaces the fixed two-operand, three-stage combinational bypass unit.

## Interface
- NUM_SRC, 2, source operands per instruction (1..4)
- NUM_STAGES, 3, forwarding stages; stage 0 = execute (youngest), stage NUM_STAGES-1 = writeback
- ADDR_W, 5, register address width
- LOAD_READY_STAGE, 1, first stage at which load data can be forwarded (1..NUM_STAGES-1)
- SEL_W, $clog2(NUM_STAGES+1), derived select width; not overridden

- clock  in  1  pipeline clock, all state on rising edge
- reset  in  1  asynchronous, active-high
- rs_addr  in  NUM_SRC*ADDR_W  decode source i at [i*ADDR_W +: ADDR_W]
- rs_valid  in  NUM_SRC  source i is actually read
- stage_rd  in  NUM_STAGES*ADDR_W  destination of stage k at [k*ADDR_W +: ADDR_W]
- stage_wen  in  NUM_STAGES  stage k writes its destination
- stage_load  in  NUM_STAGES  stage k holds a load
- hold  in  1  global pipeline freeze (e.g. memory wait)
- flush  in  1  control-flow flush of decode/execute
- stall  out  1  decode must hold; execute receives a bubble
- bypass_sel  out  NUM_SRC*SEL_W  registered execute-stage select per source: 0 = register file, k+1 = stage k
- stall_cycles  out  32  perf counter (see Configuration)
- bypass_events  out  32  perf counter (see Configuration)

## Operation
- Match(i,k) = rs_valid[i] & stage_wen[k] & (rs_addr_i == stage_rd_k) & (rs_addr_i != 0). Register x0 is never bypassed and never stalls.
- Per source, the youngest matching stage (lowest k) wins. sel_d_i = k+1, else 0.
- Load-use: the winning match for any source has stage_load[k]=1 and k < LOAD_READY_STAGE. This is detect=1.
- FSM states are IDLE and STALL, with a counter cnt of width $clog2(NUM_STAGES)+1.
  - IDLE: stall = detect. If detect and (LOAD_READY_STAGE-k) > 1, go to STALL with cnt = LOAD_READY_STAGE-k-1. With multiple sources, use the largest required count.
  - STALL: stall = 1 and detect is ignored. cnt decrements each non-hold cycle. When cnt reaches 1, return to IDLE. The decode instruction is re-evaluated on the next IDLE cycle and is then normally bypassed.
- Select register, one per source, updated on each rising edge in this priority order:
  - flush: all sel_q = 0, FSM goes to IDLE, cnt = 0.
  - else hold: sel_q, FSM and cnt all retain.
  - else stall: sel_q = 0 (bubble).
  - else: sel_q = sel_d.
- bypass_sel = sel_q.

## Timing
- Reset (asynchronous): bypass_sel = 0, FSM = IDLE, cnt = 0, stall = 0 (given no detect), counters = 0.
- Bypass latency: sel_d is computed in decode cycle t and appears on bypass_sel in cycle t+1, aligned with the instruction in execute.
- stall is combinational in the detect cycle, then registered-FSM driven. Total stall length = LOAD_READY_STAGE-k cycles, not counting hold cycles.
- With the default parameters, a load in execute followed by a dependent instruction gives exactly 1 stall cycle. The following cycle selects stage 1 (bypass_sel = 2).
- hold during STALL extends the stall one-for-one. stall stays 1 while held.
- flush in the same cycle as detect: the flush wins and no STALL state is entered. stall may still be 1 combinationally in that cycle; the pipeline ignores it under flush.
- Reset asserted mid-STALL: the unit returns to IDLE immediately, without waiting for a clock edge.

## Configuration
- BYPASS_PERF_COUNTERS_EN defined:
  - stall_cycles increments on every cycle with stall=1 & ~hold & ~flush.
  - bypass_events increments once per non-hold, non-stall cycle in which any sel_d is nonzero.
  - Both counters saturate at 32'hFFFFFFFF and clear only on reset.
- Macro undefined: both outputs are tied to 0 and no counter flops are generated.

## Test plan
- Default params; stage_rd = {wb:5, mem:5, ex:5}, all stage_wen = 1, rs_addr0 = 5 -> bypass_sel[1:0] = 2'b01 next cycle (youngest wins), stall = 0.
- rs_addr0 = 0 with stage 0 writing x0 -> bypass_sel = 0, stall = 0.
- Load in execute writing x7, rs_addr1 = 7 -> stall = 1 for 1 cycle, sel1 = 0 (bubble). Next cycle, with the load in stage 1 -> sel1 = 2, stall = 0.
- NUM_STAGES = 4, LOAD_READY_STAGE = 3, load in stage 0 matches -> stall for 3 cycles. hold asserted during the 2nd cycle -> 4 stall cycles total.
- flush during STALL -> next cycle stall = 0, bypass_sel = 0, FSM = IDLE. Asynchronous reset pulse mid-STALL -> same state immediately.
- With BYPASS_PERF_COUNTERS_EN: after the scenarios above -> stall_cycles and bypass_events match the reference count. Force stall_cycles to 32'hFFFFFFFF and stall -> counter holds 32'hFFFFFFFF.
